// File: rtl/hrav_serializer_sched.sv
`default_nettype none
// ============================================================================
// Module   : hrav_serializer_sched
// Purpose  : Round-robin scheduler that shares one wide-to-narrow serializer
//            among NUM_REQ per-source FIFOs. It grants one non-empty, enabled
//            source, pops one DINWIDTH-bit word with a single-cycle read
//            pulse, and emits that word LSB-first as DINWIDTH/DOUTWIDTH beats
//            on a valid/ready stream tagged with source index and last flag.
// Ports    : clk, reset (sync, active-high)
//            req_empty/req_mask/req_din  - FIFO bank status, enables, data
//            req_rd_en                   - one-hot registered read pulse
//            out_data/out_valid/out_ready/out_last/out_src - beat stream
//            busy                        - high whenever not idle
// Revision : 1.0 - initial release
// ============================================================================
module hrav_serializer_sched #(
  parameter int NUM_REQ   = 4,
  parameter int DINWIDTH  = 256,
  parameter int DOUTWIDTH = 8,
  parameter int SRCW      = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_empty,
  input  logic [NUM_REQ-1:0]          req_mask,
  input  logic [NUM_REQ*DINWIDTH-1:0] req_din,
  output logic [NUM_REQ-1:0]          req_rd_en,
  output logic [DOUTWIDTH-1:0]        out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_last,
  output logic [SRCW-1:0]             out_src,
  output logic                        busy
);

  localparam int BEATS = DINWIDTH / DOUTWIDTH;
  localparam int CNTW  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNTW-1:0] LAST_BEAT = CNTW'(BEATS - 1);
  localparam logic [SRCW-1:0] PTR_RST   = SRCW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    SEND  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [SRCW-1:0]       ptr_q, ptr_d;
  logic [SRCW-1:0]       src_q, src_d;
  logic [DINWIDTH-1:0]   shreg_q, shreg_d;
  logic [CNTW-1:0]       cnt_q, cnt_d;
  logic [NUM_REQ-1:0]    rd_en_q, rd_en_d;

  logic [NUM_REQ-1:0]    eligible;
  logic                  found;
  logic [SRCW-1:0]       winner;
  logic [SRCW-1:0]       rr_cand;

  assign eligible = ~req_empty & req_mask;

  // Search upward from the source after the last grant, wrapping modulo
  // NUM_REQ; the first eligible candidate wins.
  always_comb begin : rr_search
    found   = 1'b0;
    winner  = ptr_q;
    rr_cand = ptr_q;
    for (int off = 1; off <= NUM_REQ; off++) begin
      rr_cand = SRCW'((int'(ptr_q) + off) % NUM_REQ);
      if (!found && eligible[rr_cand]) begin
        found  = 1'b1;
        winner = rr_cand;
      end
    end
  end

  always_comb begin : fsm_next
    state_d = state_q;
    ptr_d   = ptr_q;
    src_d   = src_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    rd_en_d = '0;
    unique case (state_q)
      IDLE: begin
        // Eligibility is looked at only here, at least two cycles after any
        // previous read pulse, so a lagging empty flag cannot double-pop.
        if (found) begin
          ptr_d   = winner;
          src_d   = winner;
          rd_en_d = NUM_REQ'(1) << winner;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        // FIFO dout is registered: the popped word is present now.
        shreg_d = req_din[src_q*DINWIDTH +: DINWIDTH];
        cnt_d   = '0;
        state_d = SEND;
      end
      SEND: begin
        if (out_ready) begin
          shreg_d = shreg_q >> DOUTWIDTH;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= PTR_RST;
      src_q   <= '0;
      shreg_q <= '0;
      cnt_q   <= '0;
      rd_en_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      src_q   <= src_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      rd_en_q <= rd_en_d;
    end
  end

  // The registered read pulse is high exactly during ISSUE.
  assign req_rd_en = rd_en_q;
  assign out_valid = (state_q == SEND);
  assign out_data  = out_valid ? shreg_q[DOUTWIDTH-1:0] : '0;
  assign out_last  = out_valid && (cnt_q == LAST_BEAT);
  assign out_src   = src_q;
  assign busy      = (state_q != IDLE);

endmodule
`default_nettype wire
